// File: rtl/gray_fifo_pkg.sv
// Shared types and helpers for the Gray-coded FIFO pointer controller.
package gray_fifo_pkg;

  // Widest pointer supported (ADDR_WIDTH up to 16 plus the wrap bit).
  localparam int unsigned MAX_PTR_W = 17;

  // Pointer width for a given RAM address width: one extra wrap bit.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  // Default geometry.
  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH_DEF;
  localparam int unsigned PTR_W          = ADDR_WIDTH_DEF + 1;

  // Binary to reflected Gray code.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_fifo_ptr_ctrl_gray_ptr_cnt.sv
// Binary pointer with a registered Gray copy of its next value.
module gray_ptr_cnt
  import gray_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] bin_nxt,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;

  // Next pointer: flush wins, otherwise natural rollover on increment.
  always_comb begin
    bin_d = bin_q;
    if (clear) begin
      bin_d = '0;
    end else if (inc) begin
      bin_d = bin_q + WIDTH'(1);
    end
    gray_d = WIDTH'(bin2gray(MAX_PTR_W'(bin_d)));
  end

  // Pointer and Gray registers update together so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin     = bin_q;
  assign bin_nxt = bin_d;
  assign gray    = gray_q;

endmodule

// File: rtl/gray_fifo_ptr_ctrl.sv
// Pointer, flag and occupancy controller for a single-clock FIFO.
module gray_fifo_ptr_ctrl
  import gray_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_LEVEL  = 2 ** ADDR_WIDTH - 1,
  parameter int unsigned AEMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_accept,
  output logic                  rd_accept,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] wr_bin, wr_bin_nxt, rd_bin, rd_bin_nxt;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  // Accepts look only at the registered flags.
  assign wr_accept = wr_en & ~full_q;
  assign rd_accept = rd_en & ~empty_q;

  gray_ptr_cnt #(
    .WIDTH (PW)
  ) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .inc     (wr_accept),
    .bin     (wr_bin),
    .bin_nxt (wr_bin_nxt),
    .gray    (wr_ptr_gray)
  );

  gray_ptr_cnt #(
    .WIDTH (PW)
  ) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .inc     (rd_accept),
    .bin     (rd_bin),
    .bin_nxt (rd_bin_nxt),
    .gray    (rd_ptr_gray)
  );

  // Flags derive from the next pointers so they move in the same cycle as the pointers.
  always_comb begin
    count_d  = wr_bin_nxt - rd_bin_nxt;
    full_d   = (wr_bin_nxt[PW-1] != rd_bin_nxt[PW-1]) &&
               (wr_bin_nxt[PW-2:0] == rd_bin_nxt[PW-2:0]);
    empty_d  = (wr_bin_nxt == rd_bin_nxt);
    afull_d  = 32'(count_d) >= AFULL_LEVEL;
    aempty_d = 32'(count_d) <= AEMPTY_LEVEL;
    ovf_d    = wr_en & full_q;
    unf_d    = rd_en & empty_q;
    if (clear) begin
      afull_d  = 1'b0;
      aempty_d = 1'b1;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
  end

  // Flag, count and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // RAM addresses drop the wrap bit.
  assign wr_addr = wr_bin[PW-2:0];
  assign rd_addr = rd_bin[PW-2:0];

  logic unused_wrap_bits;
  assign unused_wrap_bits = wr_bin[PW-1] ^ rd_bin[PW-1];

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
